// File: rtl/ft_fifo_pkg.sv
// rtl/ft_fifo_pkg.sv - shared constants for the FT245 synchronous FIFO transfer engine
package ft_fifo_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RD_OE = 2'd1;
    localparam logic [1:0] ST_RD    = 2'd2;
    localparam logic [1:0] ST_WR    = 2'd3;

    localparam logic DIR_READ  = 1'b0;
    localparam logic DIR_WRITE = 1'b1;

    localparam int MAX_BURST_DEFAULT = 64;

endpackage

// File: rtl/ft245_sync_xfer.sv
// rtl/ft245_sync_xfer.sv - FT2232H synchronous FIFO burst engine between USB and FIFOs A/B
module ft245_sync_xfer
    import ft_fifo_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       D1,
    input  logic       D2,
    input  logic       RXF,
    input  logic       TXE,
    input  logic       FFA,
    input  logic       EFB,
    input  logic [7:0] DIN,
    output logic [7:0] DOUT,
    output logic       DOE,
    output logic       OE_N,
    output logic       RD_N,
    output logic       WR_N,
    output logic       WEA,
    output logic [7:0] DA,
    output logic       REB,
    input  logic [7:0] QB
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

    logic [1:0]    state;
    logic          last_dir;
    logic [CW-1:0] cnt;
    logic          rd_act;
    logic          wr_act;
    logic          rd_byte;
    logic          wr_byte;
    logic          last_byte;

    // Byte-moving conditions ignore rst; the strobes below are additionally gated by it
    assign rd_byte   = ~RXF & ~FFA;
    assign wr_byte   = ~TXE & ~EFB;
    assign last_byte = (cnt == LAST);

    assign rd_act = (state == ST_RD) & ~rst;
    assign wr_act = (state == ST_WR) & ~rst;

    assign OE_N = ~((state == ST_RD_OE) | (state == ST_RD));
    assign DOE  = (state == ST_WR);
    assign DOUT = (state == ST_WR) ? QB : 8'h00;
    assign DA   = DIN;
    assign RD_N = rd_act ? FFA : 1'b1;
    assign WEA  = rd_act & rd_byte;
    assign WR_N = wr_act ? EFB : 1'b1;
    assign REB  = wr_act & wr_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            last_dir <= DIR_WRITE;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    // Under contention, alternate away from the previous direction
                    if (D1 && (!D2 || last_dir == DIR_WRITE)) begin
                        state <= ST_RD_OE;
                    end else if (D2) begin
                        state <= ST_WR;
                    end
                end
                ST_RD_OE: begin
                    state <= ST_RD;
                end
                ST_RD: begin
                    if (rd_byte) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (RXF || FFA || (rd_byte && last_byte)) begin
                        state    <= ST_IDLE;
                        last_dir <= DIR_READ;
                    end
                end
                default: begin
                    if (wr_byte) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (TXE || EFB || (wr_byte && last_byte)) begin
                        state    <= ST_IDLE;
                        last_dir <= DIR_WRITE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft245_sync_xfer.sv
// tb/tb_ft245_sync_xfer.sv - directed self-checking bench for ft245_sync_xfer
module tb_ft245_sync_xfer;

    logic       clk = 1'b0;
    logic       rst, D1, D2, RXF, TXE, FFA, EFB;
    logic [7:0] DIN, DOUT, DA, QB;
    logic       DOE, OE_N, RD_N, WR_N, WEA, REB;

    logic       rst4, D14, D24, RXF4, TXE4, FFA4, EFB4;
    logic [7:0] DIN4, DOUT4, DA4, QB4;
    logic       DOE4, OE_N4, RD_N4, WR_N4, WEA4, REB4;

    int checks = 0;
    int errors = 0;
    logic [7:0] fa[$];
    logic [7:0] fb[$];

    always #5 clk = ~clk;

    ft245_sync_xfer dut (
        .clk(clk), .rst(rst), .D1(D1), .D2(D2), .RXF(RXF), .TXE(TXE),
        .FFA(FFA), .EFB(EFB), .DIN(DIN), .DOUT(DOUT), .DOE(DOE),
        .OE_N(OE_N), .RD_N(RD_N), .WR_N(WR_N), .WEA(WEA), .DA(DA),
        .REB(REB), .QB(QB)
    );

    ft245_sync_xfer #(.MAX_BURST(4)) dut4 (
        .clk(clk), .rst(rst4), .D1(D14), .D2(D24), .RXF(RXF4), .TXE(TXE4),
        .FFA(FFA4), .EFB(EFB4), .DIN(DIN4), .DOUT(DOUT4), .DOE(DOE4),
        .OE_N(OE_N4), .RD_N(RD_N4), .WR_N(WR_N4), .WEA(WEA4), .DA(DA4),
        .REB(REB4), .QB(QB4)
    );

    task automatic upd_b();
        EFB = (fb.size() == 0);
        QB  = (fb.size() != 0) ? fb[0] : 8'h00;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        if (WEA) fa.push_back(DA);
        if (REB && fb.size() != 0) void'(fb.pop_front());
        @(posedge clk);
        #1;
        upd_b();
    endtask

    task automatic test_reset();
        rst = 1'b1; D1 = 1'b1; D2 = 1'b0; RXF = 1'b0; TXE = 1'b1; FFA = 1'b0; DIN = 8'h00;
        fb.delete(); fa.delete(); upd_b();
        tick();
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if ({OE_N, RD_N, WR_N, DOE, WEA, REB, DOUT} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL reset_values got %b exp 11100000000000", {OE_N, RD_N, WR_N, DOE, WEA, REB, DOUT});
            end
            tick();
        end
        rst = 1'b0;
        settle();
        checks++;
        if (OE_N !== 1'b1) begin errors++; $display("FAIL rd_idle_oe got %b exp 1", OE_N); end
        tick();
        settle();
        checks++;
        if ({OE_N, RD_N, DOE} !== 3'b010) begin errors++; $display("FAIL rd_oe_cycle got %b exp 010", {OE_N, RD_N, DOE}); end
        tick();
        for (int i = 0; i < 10; i++) begin
            DIN = 8'(i);
            settle();
            checks++;
            if ({OE_N, RD_N, WEA, DA} !== {1'b0, 1'b0, 1'b1, 8'(i)}) begin
                errors++;
                $display("FAIL rd_burst[%0d] got %h exp %h", i, {OE_N, RD_N, WEA, DA}, {1'b0, 1'b0, 1'b1, 8'(i)});
            end
            tick();
        end
        RXF = 1'b1; D1 = 1'b0;
        settle();
        tick();
        settle();
        checks++;
        if ({OE_N, DOE, RD_N} !== 3'b101) begin errors++; $display("FAIL rd_back_idle got %b exp 101", {OE_N, DOE, RD_N}); end
        checks++;
        if (fa.size() != 10) begin
            errors++;
            $display("FAIL rd_count got %0d exp 10", fa.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (fa[i] !== 8'(i)) begin errors++; $display("FAIL rd_data[%0d] got %h exp %h", i, fa[i], 8'(i)); end
            end
        end
        tick();
    endtask

    task automatic test_write();
        int pulses = 0;
        fb.delete();
        for (int i = 0; i < 5; i++) fb.push_back(8'hA0 + 8'(i));
        upd_b();
        TXE = 1'b0; D2 = 1'b1; RXF = 1'b1; D1 = 1'b0;
        settle();
        checks++;
        if ({WR_N, DOE} !== 2'b10) begin errors++; $display("FAIL wr_idle got %b exp 10", {WR_N, DOE}); end
        tick();
        D2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++;
            if ({WR_N, REB, DOE, DOUT} !== {1'b0, 1'b1, 1'b1, 8'hA0 + 8'(i)}) begin
                errors++;
                $display("FAIL wr_burst[%0d] got %h exp %h", i, {WR_N, REB, DOE, DOUT}, {1'b0, 1'b1, 1'b1, 8'hA0 + 8'(i)});
            end
            if (REB) pulses++;
            tick();
        end
        settle();
        checks++;
        if ({WR_N, REB} !== 2'b10) begin errors++; $display("FAIL wr_empty_stop got %b exp 10", {WR_N, REB}); end
        tick();
        settle();
        checks++;
        if ({DOE, DOUT, WR_N} !== {1'b0, 8'h00, 1'b1}) begin errors++; $display("FAIL wr_back_idle got %h exp 001", {DOE, DOUT, WR_N}); end
        checks++;
        if (pulses != 5 || fb.size() != 0) begin errors++; $display("FAIL wr_pops got %0d left %0d exp 5 left 0", pulses, fb.size()); end
        TXE = 1'b1;
        tick();
    endtask

    task automatic test_alternate();
        logic [5:0] exp_code[17];
        for (int c = 0; c < 17; c++) begin
            if (c == 0 || c == 6 || c == 11)      exp_code[c] = 6'b110100;
            else if (c == 1 || c == 12)           exp_code[c] = 6'b010100;
            else if (c >= 7 && c <= 10)           exp_code[c] = 6'b110011;
            else                                  exp_code[c] = 6'b001100;
        end
        D14 = 1'b1; D24 = 1'b1; RXF4 = 1'b0; TXE4 = 1'b0; FFA4 = 1'b0; EFB4 = 1'b0;
        rst4 = 1'b0;
        for (int c = 0; c < 17; c++) begin
            settle();
            checks++;
            if ({OE_N4, RD_N4, WEA4, WR_N4, REB4, DOE4} !== exp_code[c]) begin
                errors++;
                $display("FAIL alt_burst[%0d] got %b exp %b", c, {OE_N4, RD_N4, WEA4, WR_N4, REB4, DOE4}, exp_code[c]);
            end
            checks++;
            if (DOE4 && !OE_N4) begin errors++; $display("FAIL alt_contention[%0d] got DOE=1 OE_N=0 exp not both", c); end
            tick();
        end
        rst4 = 1'b1;
        tick();
    endtask

    task automatic test_ffa_pulse();
        int rdlow = 0;
        logic [7:0] exp_bytes[5];
        exp_bytes[0] = 8'h12; exp_bytes[1] = 8'h13; exp_bytes[2] = 8'h14;
        exp_bytes[3] = 8'h18; exp_bytes[4] = 8'h19;
        fa.delete();
        D1 = 1'b1; D2 = 1'b0; RXF = 1'b0;
        for (int c = 0; c < 10; c++) begin
            FFA = (c == 5 || c == 6);
            DIN = 8'h10 + 8'(c);
            settle();
            if (c == 5 || c == 6) begin
                checks++;
                if ({RD_N, WEA} !== 2'b10) begin errors++; $display("FAIL ffa_suppress[%0d] got %b exp 10", c, {RD_N, WEA}); end
            end
            if (!RD_N && !RXF) rdlow++;
            tick();
        end
        FFA = 1'b0; D1 = 1'b0; RXF = 1'b1;
        settle();
        tick();
        checks++;
        if (fa.size() != rdlow) begin errors++; $display("FAIL ffa_count_vs_rdn got %0d exp %0d", fa.size(), rdlow); end
        checks++;
        if (fa.size() != 5) begin
            errors++;
            $display("FAIL ffa_count got %0d exp 5", fa.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (fa[i] !== exp_bytes[i]) begin errors++; $display("FAIL ffa_data[%0d] got %h exp %h", i, fa[i], exp_bytes[i]); end
            end
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        fb.delete();
        for (int i = 0; i < 5; i++) fb.push_back(8'hB0 + 8'(i));
        upd_b();
        D2 = 1'b1; D1 = 1'b0; TXE = 1'b0; RXF = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            tick();
        end
        rst = 1'b1;
        settle();
        checks++;
        if ({WR_N, REB} !== 2'b10) begin errors++; $display("FAIL rst_strobes got %b exp 10", {WR_N, REB}); end
        tick();
        D2 = 1'b0;
        settle();
        checks++;
        if (fb.size() != 3) begin errors++; $display("FAIL rst_popped got %0d exp 2", 5 - fb.size()); end
        checks++;
        if ({OE_N, RD_N, WR_N, DOE, WEA, REB, DOUT} !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rst_after got %b exp 11100000000000", {OE_N, RD_N, WR_N, DOE, WEA, REB, DOUT});
        end
        tick();
        rst = 1'b0; TXE = 1'b1;
        fb.delete(); upd_b();
        tick();
    endtask

    task automatic test_txe_toggle();
        logic [7:0] got[$];
        fb.delete();
        for (int i = 0; i < 8; i++) fb.push_back(8'hC0 + 8'(i));
        upd_b();
        D2 = 1'b1; D1 = 1'b0; RXF = 1'b1;
        for (int c = 0; c < 15; c++) begin
            TXE = (c % 3 == 2);
            settle();
            checks++;
            if (REB !== (c % 3 == 1)) begin errors++; $display("FAIL txe_reb[%0d] got %b exp %b", c, REB, (c % 3 == 1)); end
            if (REB) got.push_back(DOUT);
            tick();
        end
        D2 = 1'b0; TXE = 1'b1;
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL txe_count got %0d exp 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL txe_order[%0d] got %h exp %h", i, got[i], 8'hC0 + 8'(i)); end
            end
        end
        tick();
    endtask

    initial begin
        rst4 = 1'b1; D14 = 1'b0; D24 = 1'b0; RXF4 = 1'b1; TXE4 = 1'b1;
        FFA4 = 1'b0; EFB4 = 1'b1; DIN4 = 8'h00; QB4 = 8'h55;
        test_reset();
        test_write();
        test_alternate();
        test_ffa_pulse();
        test_reset_mid_write();
        test_txe_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
